// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared constants and state encodings for the serial program
//             loader and its UART receiver.
//  Revision : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    // First byte of every load frame
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    // Data bits per UART character (8N1)
    localparam int c_UART_DATA_BITS = 8;

    // Loader frame-parser states
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LEN  = 2'd1,
        LD_DATA = 2'd2,
        LD_CHK  = 2'd3
    } ld_state_e;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_uart_rx
//  Purpose  : 8N1 UART receiver, LSB first. Synchronises the serial line,
//             validates the start bit at its centre, samples data at bit
//             centres and checks the stop bit.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_LAST_BIT = 3'(c_UART_DATA_BITS - 1);

    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Next-state logic: synchroniser chain, bit timer and shift register
    always_comb begin
        rx_meta_d = i_rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // falling edge of the synchronised line starts a character
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == c_HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // a start bit that is high again at its centre was a glitch
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == c_LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State registers; the line is assumed idle (high) out of reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_byte       = shift_q;
    assign o_byte_valid = valid_q;
    assign o_frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Serial program loader. Parses A5/LEN/data/CHK frames from the
//             UART, writes data bytes into program memory from address 0 and
//             releases the CPU from reset after a checksum-verified image.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [8:0]       c_MAX_LEN  = 9'(2 ** ADDR_W);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] rx_byte;

    prog_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .o_byte       (rx_byte),
        .o_byte_valid (rx_valid),
        .o_frame_err  (rx_ferr)
    );

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              len_ok;
    logic [CNT_W-1:0]  idx_inc;
    logic [7:0]        chk_sum;

    assign len_ok  = (rx_byte != 8'h00) && ({1'b0, rx_byte} <= c_MAX_LEN);
    assign idx_inc = idx_q + CNT_W'(1);
    assign chk_sum = sum_q + rx_byte;

    // Frame parser, checksum accumulation and inter-byte timeout
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        hold_d    = hold_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // gap timer runs only inside a frame and restarts on every byte
        tmr_d = (state_q == LD_IDLE || rx_valid) ? '0 : tmr_q + TMR_W'(1);
        case (state_q)
            LD_IDLE: begin
                if (rx_valid && rx_byte == c_SYNC_BYTE) begin
                    state_d = LD_LEN;
                    hold_d  = 1'b1;
                end
            end
            LD_LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        len_d   = CNT_W'(rx_byte);
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = LD_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LD_IDLE;
                    end
                end
            end
            LD_DATA: begin
                // every byte here is payload, including a stray sync value
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[ADDR_W-1:0];
                    wr_data_d = rx_byte;
                    sum_d     = chk_sum;
                    idx_d     = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = LD_CHK;
                    end
                end
            end
            LD_CHK: begin
                if (rx_valid) begin
                    if (chk_sum == 8'h00) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = LD_IDLE;
                end
            end
            default: state_d = LD_IDLE;
        endcase
        // abort on a broken character or a stalled sender; already written
        // bytes stay in memory and the CPU stays held
        if (state_q != LD_IDLE && !rx_valid && (rx_ferr || tmr_q == c_TMR_LAST)) begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
        end
    end

    // Loader registers, all outputs registered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= LD_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            tmr_q     <= tmr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_cpu_hold = hold_q;
    assign o_busy     = (state_q != LD_IDLE);
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader: good image, bad
//             checksum, bad lengths, maximum length, leading junk, framing
//             error, inter-byte timeout and asynchronous reset mid-byte.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;
    localparam int TO  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_cpu_hold (cpu_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Write / pulse log, sampled on the falling edge
    logic [AW-1:0] wa_log [0:31];
    logic [7:0]    wd_log [0:31];
    int nwr = 0, ndone = 0, nerr = 0, nboth = 0;
    int last_wr_cyc = 0, err_cyc = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            if (nwr < 32) begin
                wa_log[nwr] = wr_addr;
                wd_log[nwr] = wr_data;
            end
            nwr++;
            last_wr_cyc = cyc;
        end
        if (done) ndone++;
        if (err) begin
            nerr++;
            err_cyc = cyc;
        end
        if (done && err) nboth++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        nwr = 0; ndone = 0; nerr = 0; nboth = 0;
    endtask

    task automatic bit_out(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_v);
        bit_out(1'b1);
        bit_out(1'b1);
    endtask

    task automatic send_frame1();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h51); send_byte(8'hE0); send_byte(8'hFF);
        send_byte(8'hD0);
    endtask

    task automatic check_frame1(input string t);
        check({t, "_nwr"},  nwr, 3);
        check({t, "_a0"},   wa_log[0], 0);
        check({t, "_d0"},   wd_log[0], 8'h51);
        check({t, "_a1"},   wa_log[1], 1);
        check({t, "_d1"},   wd_log[1], 8'hE0);
        check({t, "_a2"},   wa_log[2], 2);
        check({t, "_d2"},   wd_log[2], 8'hFF);
        check({t, "_done"}, ndone, 1);
        check({t, "_err"},  nerr, 0);
        check({t, "_hold"}, cpu_hold, 0);
        check({t, "_busy"}, busy, 0);
    endtask

    task automatic check_reset_outs(input string t);
        check({t, "_hold"},  cpu_hold, 1);
        check({t, "_wr_en"}, wr_en, 0);
        check({t, "_addr"},  wr_addr, 0);
        check({t, "_data"},  wr_data, 0);
        check({t, "_busy"},  busy, 0);
        check({t, "_done"},  done, 0);
        check({t, "_err"},   err, 0);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);

        // good 3-byte image
        clear_logs();
        send_frame1();
        check_frame1("c1");

        // bad checksum; sync must raise hold again
        clear_logs();
        send_byte(8'hA5);
        check("c2_hold_sync", cpu_hold, 1);
        check("c2_busy_sync", busy, 1);
        send_byte(8'h01); send_byte(8'h0F); send_byte(8'h00);
        check("c2_nwr",  nwr, 1);
        check("c2_a0",   wa_log[0], 0);
        check("c2_d0",   wd_log[0], 8'h0F);
        check("c2_err",  nerr, 1);
        check("c2_done", ndone, 0);
        check("c2_hold", cpu_hold, 1);

        // LEN out of range at both ends
        clear_logs();
        send_byte(8'hA5); send_byte(8'h00);
        check("c3_err_len0", nerr, 1);
        send_byte(8'hA5); send_byte(8'h11);
        check("c3_err_len17", nerr, 2);
        check("c3_nwr", nwr, 0);
        check("c3_busy", busy, 0);

        // maximum image: 16 x 0x01, checksum 0xF0
        clear_logs();
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        send_byte(8'hF0);
        check("max_nwr",  nwr, 16);
        check("max_a15",  wa_log[15], 15);
        check("max_d15",  wd_log[15], 8'h01);
        check("max_done", ndone, 1);
        check("max_err",  nerr, 0);
        check("max_hold", cpu_hold, 0);

        // leading junk then a good image
        clear_logs();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        send_frame1();
        check_frame1("c4");

        // framing error on the second data byte
        clear_logs();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h51); send_byte(8'hE0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("c5_nwr",  nwr, 1);
        check("c5_d0",   wd_log[0], 8'h51);
        check("c5_err",  nerr, 1);
        check("c5_done", ndone, 0);
        check("c5_hold", cpu_hold, 1);
        check("c5_busy", busy, 0);

        // stalled sender: err TIMEOUT+1 cycles after the last byte_valid,
        // i.e. TIMEOUT cycles after the write strobe it caused
        clear_logs();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        for (int k = 0; k < TO + 200 && nerr == 0; k++) @(negedge clk);
        check("c6_err_seen", nerr, 1);
        check("c6_nwr", nwr, 1);
        check("c6_d0", wd_log[0], 8'h11);
        check("c6_gap", err_cyc - last_wr_cyc, TO);
        check("c6_hold", cpu_hold, 1);

        // asynchronous reset in the middle of a character
        clear_logs();
        send_byte(8'hA5);
        bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        check("c6_busy_pre_rst", busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_outs("c6_rst");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        clear_logs();
        send_frame1();
        check_frame1("c6_reload");
        check("both_pulses", nboth, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
